// File: rtl/dsa_pixel_fetch_if.sv
// Bus bundle between dsa_pixel_fetch and its environment: the source-memory
// read port, the bilinear datapath request/response and the destination
// write port.
interface dsa_pixel_fetch_if #(
  parameter int ADDR_W = 16
);
  // Handshake rules: mem_rd_data is valid exactly one cycle after mem_rd_en;
  // dp_start is a one-cycle request and dp_p*/dp_a/dp_b are held from
  // dp_start until the one-cycle dp_done (with dp_pixel) response;
  // wr_en is a one-cycle write strobe with no back-pressure.
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic              dp_start;
  logic [7:0]        dp_p00;
  logic [7:0]        dp_p01;
  logic [7:0]        dp_p10;
  logic [7:0]        dp_p11;
  logic [15:0]       dp_a;
  logic [15:0]       dp_b;
  logic              dp_done;
  logic [7:0]        dp_pixel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output mem_rd_en, mem_rd_addr, dp_start, dp_p00, dp_p01, dp_p10, dp_p11,
           dp_a, dp_b, wr_en, wr_addr, wr_data,
    input  mem_rd_data, dp_done, dp_pixel
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, dp_start, dp_p00, dp_p01, dp_p10, dp_p11,
           dp_a, dp_b, wr_en, wr_addr, wr_data,
    output mem_rd_data, dp_done, dp_pixel
  );
endinterface

// File: rtl/dsa_pixel_fetch.sv
// dsa_pixel_fetch: raster-order sequencer for the bilinear datapath.
// For every destination pixel it derives Q8.8 source coordinates, reads the
// four neighbours, runs the datapath once and writes the result.
// Optional build macro DSA_FETCH_PERF_EN adds perf_cycles / perf_reads.
module dsa_pixel_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DIM_W    = 10,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  dst_w,
  input  logic [DIM_W-1:0]  dst_h,
  input  logic [15:0]       scale_inv,
  dsa_pixel_fetch_if.master bus,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        state_dbg
`ifdef DSA_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_reads
`endif
);

  localparam int ACC_W = DIM_W + 16;
  localparam int INT_W = ACC_W - 8;
  localparam logic [DIM_W-1:0] ONE_D = 1;

  typedef enum logic [3:0] {
    IDLE, CALC, RD0, RD1, RD2, RD3, CAP, FIRE, WAIT_DP, WRITE, FIN
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [15:0]       scale_q;
  logic [DIM_W-1:0]  dx, dy;
  logic [ACC_W-1:0]  x_acc, y_acc;
  logic [DIM_W-1:0]  x0_q, x1_q;
  logic [ADDR_W-1:0] row0, row1;

  logic [INT_W-1:0]  xi_raw, yi_raw;
  logic [DIM_W-1:0]  x_last, y_last;
  logic [DIM_W-1:0]  xi_c, x1_c, yi_c, y1_c;
  logic [7:0]        xf_c, yf_c;
  logic [ADDR_W-1:0] row0_c, row1_c;

  assign state_dbg = state;

  // Integer/fraction split of the accumulators with edge clamping; a clamped
  // axis interpolates a pixel against itself, so its fraction is zeroed.
  always_comb begin
    xi_raw = x_acc[ACC_W-1:8];
    yi_raw = y_acc[ACC_W-1:8];
    x_last = src_w_q - ONE_D;
    y_last = src_h_q - ONE_D;
    xi_c   = xi_raw[DIM_W-1:0];
    x1_c   = xi_raw[DIM_W-1:0] + ONE_D;
    xf_c   = x_acc[7:0];
    yi_c   = yi_raw[DIM_W-1:0];
    y1_c   = yi_raw[DIM_W-1:0] + ONE_D;
    yf_c   = y_acc[7:0];
    if (xi_raw >= INT_W'(x_last)) begin
      xi_c = x_last;
      x1_c = x_last;
      xf_c = 8'h00;
    end
    if (yi_raw >= INT_W'(y_last)) begin
      yi_c = y_last;
      y1_c = y_last;
      yf_c = 8'h00;
    end
    row0_c = ADDR_W'(yi_c) * ADDR_W'(src_w_q);
    row1_c = ADDR_W'(y1_c) * ADDR_W'(src_w_q);
  end

  // Frame sequencer: every output is registered and set on entry to the
  // state in which it must be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      src_w_q         <= '0;
      src_h_q         <= '0;
      dst_w_q         <= '0;
      dst_h_q         <= '0;
      scale_q         <= '0;
      dx              <= '0;
      dy              <= '0;
      x_acc           <= '0;
      y_acc           <= '0;
      x0_q            <= '0;
      x1_q            <= '0;
      row0            <= '0;
      row1            <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.dp_start    <= 1'b0;
      bus.dp_p00      <= '0;
      bus.dp_p01      <= '0;
      bus.dp_p10      <= '0;
      bus.dp_p11      <= '0;
      bus.dp_a        <= '0;
      bus.dp_b        <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_w_q <= src_w;
            src_h_q <= src_h;
            dst_w_q <= dst_w;
            dst_h_q <= dst_h;
            scale_q <= scale_inv;
            dx      <= '0;
            dy      <= '0;
            x_acc   <= '0;
            y_acc   <= '0;
            busy    <= 1'b1;
            if (dst_w == '0 || dst_h == '0) begin
              frame_done <= 1'b1;
              state      <= FIN;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          x0_q            <= xi_c;
          x1_q            <= x1_c;
          row0            <= row0_c;
          row1            <= row1_c;
          bus.dp_a        <= {8'h00, xf_c};
          bus.dp_b        <= {8'h00, yf_c};
          bus.mem_rd_en   <= 1'b1;
          bus.mem_rd_addr <= row0_c + ADDR_W'(xi_c);
          state           <= RD0;
        end
        RD0: begin
          bus.mem_rd_addr <= row0 + ADDR_W'(x1_q);
          state           <= RD1;
        end
        RD1: begin
          bus.dp_p00      <= bus.mem_rd_data;
          bus.mem_rd_addr <= row1 + ADDR_W'(x0_q);
          state           <= RD2;
        end
        RD2: begin
          bus.dp_p01      <= bus.mem_rd_data;
          bus.mem_rd_addr <= row1 + ADDR_W'(x1_q);
          state           <= RD3;
        end
        RD3: begin
          bus.dp_p10      <= bus.mem_rd_data;
          bus.mem_rd_en   <= 1'b0;
          bus.mem_rd_addr <= '0;
          state           <= CAP;
        end
        CAP: begin
          bus.dp_p11   <= bus.mem_rd_data;
          bus.dp_start <= 1'b1;
          state        <= FIRE;
        end
        FIRE: begin
          bus.dp_start <= 1'b0;
          state        <= WAIT_DP;
        end
        WAIT_DP: begin
          if (bus.dp_done) begin
            bus.wr_data <= bus.dp_pixel;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= DST_BASE + ADDR_W'(dy) * ADDR_W'(dst_w_q) + ADDR_W'(dx);
            state       <= WRITE;
          end
        end
        WRITE: begin
          bus.wr_en <= 1'b0;
          if (dx == dst_w_q - ONE_D) begin
            if (dy == dst_h_q - ONE_D) begin
              frame_done <= 1'b1;
              state      <= FIN;
            end else begin
              dx    <= '0;
              x_acc <= '0;
              dy    <= dy + ONE_D;
              y_acc <= y_acc + ACC_W'(scale_q);
              state <= CALC;
            end
          end else begin
            dx    <= dx + ONE_D;
            x_acc <= x_acc + ACC_W'(scale_q);
            state <= CALC;
          end
        end
        FIN: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DSA_FETCH_PERF_EN
  // perf_cycles runs one cycle ahead of busy so the value shown alongside
  // frame_done already includes the FIN cycle; both hold once idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_reads  <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= 32'd1;
      perf_reads  <= '0;
    end else begin
      if (busy && state != FIN) perf_cycles <= perf_cycles + 32'd1;
      if (bus.mem_rd_en) perf_reads <= perf_reads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsa_pixel_fetch.sv
// Directed bench for dsa_pixel_fetch: table of frame scenarios driven
// through a source-memory model and a variable-latency datapath model, plus
// hand sequences for reset state, a stray dp_done and reset mid-frame.
module tb_dsa_pixel_fetch;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 10;

  typedef struct {
    int sw, sh, dw, dh;
    int scale;
    int lat;
    int restart;
    int exp_wr, exp_rd;
    int exp_last_addr, exp_last_data;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [DIM_W-1:0] src_w, src_h, dst_w, dst_h;
  logic [15:0]      scale_inv;
  logic             busy, frame_done;
  logic [3:0]       state_dbg;
`ifdef DSA_FETCH_PERF_EN
  logic [31:0]      perf_cycles, perf_reads;
`endif

  dsa_pixel_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  dsa_pixel_fetch #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .DST_BASE(16'h8000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_w      (src_w),
    .src_h      (src_h),
    .dst_w      (dst_w),
    .dst_h      (dst_h),
    .scale_inv  (scale_inv),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
`ifdef DSA_FETCH_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_reads (perf_reads)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int rd_cnt, wr_cnt, fd_cnt;
  bit excl_err, stab_err, waiting;
  bit sb_en;
  logic [15:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  logic [63:0] snap;

  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_ab_q[$];
  logic [23:0] exp_wr_q[$];

  logic [7:0] src_mem [256];
  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int bilin(input int p00, p01, p10, p11, a, b);
    int top, bot;
    top = p00 * (256 - a) + p01 * a;
    bot = p10 * (256 - a) + p11 * a;
    return (top * (256 - b) + bot * b) >> 16;
  endfunction

  function automatic logic [127:0] all_outs();
    return {19'd0, bus.mem_rd_en, bus.mem_rd_addr, bus.dp_start,
            bus.dp_p00, bus.dp_p01, bus.dp_p10, bus.dp_p11, bus.dp_a, bus.dp_b,
            bus.wr_en, bus.wr_addr, bus.wr_data, busy, frame_done};
  endfunction

  // ---------------- environment models ----------------
  int         dp_lat;
  int         dp_cnt;
  logic [7:0] dp_res;
  logic       stray_req;

  always @(posedge clk) bus.mem_rd_data <= src_mem[bus.mem_rd_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      dp_cnt       <= 0;
      bus.dp_done  <= 1'b0;
      bus.dp_pixel <= 8'h00;
    end else begin
      bus.dp_done <= stray_req;
      if (bus.dp_start) begin
        if (dp_lat <= 1) begin
          bus.dp_done  <= 1'b1;
          bus.dp_pixel <= 8'(bilin(bus.dp_p00, bus.dp_p01, bus.dp_p10, bus.dp_p11,
                                   bus.dp_a, bus.dp_b));
        end else begin
          dp_cnt <= dp_lat - 1;
          dp_res <= 8'(bilin(bus.dp_p00, bus.dp_p01, bus.dp_p10, bus.dp_p11,
                             bus.dp_a, bus.dp_b));
        end
      end else if (dp_cnt > 0) begin
        dp_cnt <= dp_cnt - 1;
        if (dp_cnt == 1) begin
          bus.dp_done  <= 1'b1;
          bus.dp_pixel <= dp_res;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      waiting = 1'b0;
    end else begin
      if ((int'(bus.mem_rd_en) + int'(bus.dp_start) + int'(bus.wr_en) + int'(frame_done)) > 1)
        excl_err = 1'b1;
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (sb_en) begin
          if (exp_rd_q.size() == 0) check("rd_unexpected", bus.mem_rd_addr, 0);
          else check("rd_addr", bus.mem_rd_addr, exp_rd_q.pop_front());
        end
      end
      if (bus.dp_start) begin
        snap    = {bus.dp_p00, bus.dp_p01, bus.dp_p10, bus.dp_p11, bus.dp_a, bus.dp_b};
        waiting = 1'b1;
        if (sb_en) begin
          if (exp_ab_q.size() == 0) check("ab_unexpected", {bus.dp_a, bus.dp_b}, 0);
          else check("dp_a_b", {bus.dp_a, bus.dp_b}, exp_ab_q.pop_front());
        end
      end else if (waiting) begin
        if ({bus.dp_p00, bus.dp_p01, bus.dp_p10, bus.dp_p11, bus.dp_a, bus.dp_b} !== snap)
          stab_err = 1'b1;
        if (bus.dp_done) waiting = 1'b0;
      end
      if (bus.wr_en) begin
        wr_cnt++;
        last_wr_addr = bus.wr_addr;
        last_wr_data = bus.wr_data;
        if (sb_en) begin
          if (exp_wr_q.size() == 0) check("wr_unexpected", {bus.wr_addr, bus.wr_data}, 0);
          else check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_wr_q.pop_front());
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- reference expectations ----------------
  task automatic model_frame(input vec_t v);
    longint mask, xacc, yacc;
    int xi, x1, yi, y1, a, b;
    logic [15:0] ad [4];
    int px [4];
    mask = (longint'(1) << 26) - 1;
    for (int dy = 0; dy < v.dh; dy++) begin
      for (int dx = 0; dx < v.dw; dx++) begin
        xacc = (longint'(dx) * longint'(v.scale)) & mask;
        yacc = (longint'(dy) * longint'(v.scale)) & mask;
        xi = int'(xacc >> 8);
        yi = int'(yacc >> 8);
        if (xi >= v.sw - 1) begin xi = v.sw - 1; x1 = xi; a = 0; end
        else begin x1 = xi + 1; a = int'(xacc & 255); end
        if (yi >= v.sh - 1) begin yi = v.sh - 1; y1 = yi; b = 0; end
        else begin y1 = yi + 1; b = int'(yacc & 255); end
        ad[0] = 16'(yi * v.sw + xi);
        ad[1] = 16'(yi * v.sw + x1);
        ad[2] = 16'(y1 * v.sw + xi);
        ad[3] = 16'(y1 * v.sw + x1);
        for (int k = 0; k < 4; k++) begin
          exp_rd_q.push_back(ad[k]);
          px[k] = int'(src_mem[ad[k][7:0]]);
        end
        exp_ab_q.push_back({16'(a), 16'(b)});
        exp_wr_q.push_back({16'(32'h8000 + dy * v.dw + dx),
                            8'(bilin(px[0], px[1], px[2], px[3], a, b))});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input vec_t v);
    int  cyc, npix;
    bit  timeout;
    rd_cnt = 0; wr_cnt = 0; fd_cnt = 0;
    excl_err = 1'b0; stab_err = 1'b0;
    last_wr_addr = '0; last_wr_data = '0;
    dp_lat = v.lat;
    exp_rd_q.delete(); exp_ab_q.delete(); exp_wr_q.delete();
    model_frame(v);
    npix = v.dw * v.dh;
    src_w = DIM_W'(v.sw); src_h = DIM_W'(v.sh);
    dst_w = DIM_W'(v.dw); dst_h = DIM_W'(v.dh);
    scale_inv = 16'(v.scale);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = -1;
    timeout = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (frame_done) begin
        timeout = 1'b0;
        cyc = c;
        break;
      end
      start = (v.restart != 0 && c == 12);
      tick();
    end
    start = 1'b0;
    check("frame_done_timeout", timeout, 0);
    check("frame_latency", cyc, npix * (8 + v.lat));
`ifdef DSA_FETCH_PERF_EN
    check("perf_cycles", perf_cycles, npix * (8 + v.lat) + 1);
    check("perf_reads", perf_reads, 4 * npix);
`endif
    tick();
    check("frame_done_pulse", frame_done, 0);
    check("busy_after_fin", busy, 0);
    repeat (3) tick();
    check("write_count", wr_cnt, v.exp_wr);
    check("read_count", rd_cnt, v.exp_rd);
    check("frame_done_count", fd_cnt, 1);
    if (v.exp_last_addr >= 0) check("last_wr_addr", last_wr_addr, v.exp_last_addr);
    if (v.exp_last_data >= 0) check("last_wr_data", last_wr_data, v.exp_last_data);
    check("exp_left", exp_rd_q.size() + exp_ab_q.size() + exp_wr_q.size(), 0);
    check("strobe_exclusive", excl_err, 0);
    check("operand_hold", stab_err, 0);
`ifdef DSA_FETCH_PERF_EN
    check("perf_cycles_hold", perf_cycles, npix * (8 + v.lat) + 1);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  n_starts;
    bit  found;
    vecs[0] = '{2, 2, 2, 2, 'h80,  1, 0,  4, 16, 'h8003, 130};
    vecs[1] = '{2, 2, 3, 1, 'h100, 2, 0,  3, 12, 'h8002, 120};
    vecs[2] = '{2, 2, 2, 2, 'h80,  7, 1,  4, 16, 'h8003, 130};
    vecs[3] = '{4, 3, 5, 4, 'hC0,  3, 0, 20, 80, 'h8013, -1};
    vecs[4] = '{2, 2, 2, 2, 'h80,  3, 0,  4, 16, 'h8003, 130};
    vecs[5] = '{2, 2, 0, 2, 'h80,  1, 0,  0,  0, -1,     -1};
    vecs[6] = '{3, 2, 4, 0, 'h100, 2, 0,  0,  0, -1,     -1};
    for (int i = 0; i < 256; i++) src_mem[i] = 8'((100 + 20 * i) & 255);

    rst = 1'b1; start = 1'b0; stray_req = 1'b0; sb_en = 1'b1; dp_lat = 1;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; scale_inv = '0;
    rd_cnt = 0; wr_cnt = 0; fd_cnt = 0;
    repeat (3) tick();
    check("reset_outputs_zero", |all_outs(), 0);
    check("reset_busy", busy, 0);
`ifdef DSA_FETCH_PERF_EN
    check("reset_perf", perf_cycles | perf_reads, 0);
`endif
    rst = 1'b0;
    tick();

    // Stray dp_done while idle must not produce a write.
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    repeat (4) tick();
    check("stray_done_writes", wr_cnt, 0);
    check("stray_done_busy", busy, 0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset during WAIT_DP of the third pixel, then a fresh full frame.
    sb_en = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    dp_lat = 6;
    src_w = 2; src_h = 2; dst_w = 2; dst_h = 2; scale_inv = 16'h0080;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_starts = 0;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (bus.dp_start) n_starts++;
      if (n_starts == 3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_seq_found_pixel2", found, 1);
    tick();
    tick();
    check("rst_seq_writes_before", wr_cnt, 2);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs_zero", |all_outs(), 0);
`ifdef DSA_FETCH_PERF_EN
    check("rst_mid_perf", perf_cycles | perf_reads, 0);
`endif
    rst = 1'b0;
    repeat (15) tick();
    check("rst_mid_no_write", wr_cnt, 2);
    check("rst_mid_idle", busy, 0);
    sb_en = 1'b1;
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
